// File: rtl/alarm_pkg.sv
// Shared types and constants for the watch mode/alarm controller.
// Digit limits bound each BCD edit position; the alarm resets to 07:00.
package alarm_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RING      = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        D_HD = 2'd0,
        D_HO = 2'd1,
        D_MD = 2'd2,
        D_MO = 2'd3
    } digit_t;

    localparam logic [3:0] HD_MAX    = 4'd2;
    localparam logic [3:0] HO_MAX    = 4'd9;
    localparam logic [3:0] HO_MAX_20 = 4'd3;
    localparam logic [3:0] MD_MAX    = 4'd5;
    localparam logic [3:0] MO_MAX    = 4'd9;

    localparam logic [3:0] ALARM_RST_HD = 4'd0;
    localparam logic [3:0] ALARM_RST_HO = 4'd7;
    localparam logic [3:0] ALARM_RST_MD = 4'd0;
    localparam logic [3:0] ALARM_RST_MO = 4'd0;

    // Wraps to 0 at the limit; anything already past it (bad BCD) also goes to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? 4'd0 : val + 4'd1;
    endfunction

endpackage

// File: rtl/alarm_digit_edit.sv
// Four-digit BCD edit buffer with a digit pointer, bulk load and
// per-digit increment that keeps hours within 00..23.
module alarm_digit_edit
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] src_hd,
    input  logic [3:0] src_ho,
    input  logic [3:0] src_md,
    input  logic [3:0] src_mo,
    input  logic       next,
    input  logic       inc,
    output logic [3:0] edit_hd,
    output logic [3:0] edit_ho,
    output logic [3:0] edit_md,
    output logic [3:0] edit_mo,
    output logic [1:0] edit_digit
);

    digit_t     sel;
    logic [3:0] hd_new;
    logic [3:0] ho_max;

    assign sel    = digit_t'(edit_digit);
    assign hd_new = bcd_inc(edit_hd, HD_MAX);
    assign ho_max = (edit_hd == HD_MAX) ? HO_MAX_20 : HO_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            edit_hd    <= 4'd0;
            edit_ho    <= 4'd0;
            edit_md    <= 4'd0;
            edit_mo    <= 4'd0;
            edit_digit <= 2'd0;
        end else if (load) begin
            edit_hd    <= src_hd;
            edit_ho    <= src_ho;
            edit_md    <= src_md;
            edit_mo    <= src_mo;
            edit_digit <= 2'd0;
        end else if (next) begin
            edit_digit <= edit_digit + 2'd1;
        end else if (inc) begin
            unique case (sel)
                D_HD: begin
                    edit_hd <= hd_new;
                    // Stepping into the 20s must not leave an hour like 27.
                    if (hd_new == HD_MAX && edit_ho > HO_MAX_20)
                        edit_ho <= HO_MAX_20;
                end
                D_HO: edit_ho <= bcd_inc(edit_ho, ho_max);
                D_MD: edit_md <= bcd_inc(edit_md, MD_MAX);
                D_MO: edit_mo <= bcd_inc(edit_mo, MO_MAX);
            endcase
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Watch mode sequencer: time/alarm setting, alarm compare and bounded
// buzzer ring, plus the display source mux.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       sec_tick,
    input  logic [3:0] now_hd,
    input  logic [3:0] now_ho,
    input  logic [3:0] now_md,
    input  logic [3:0] now_mo,
    output logic       load_en,
    output logic [3:0] set_hd,
    output logic [3:0] set_ho,
    output logic [3:0] set_md,
    output logic [3:0] set_mo,
    output logic [3:0] disp_hd,
    output logic [3:0] disp_ho,
    output logic [3:0] disp_md,
    output logic [3:0] disp_mo,
    output logic [1:0] edit_digit,
    output logic       blink,
    output logic [1:0] mode,
    output logic       alarm_armed,
    output logic       buzzer
);

    localparam logic [7:0] RING_LOAD = 8'(RING_SECONDS);

    mode_t      state, state_nx;
    logic [3:0] alarm_hd, alarm_ho, alarm_md, alarm_mo;
    logic [3:0] edit_hd, edit_ho, edit_md, edit_mo;
    logic [3:0] src_hd, src_ho, src_md, src_mo;
    logic [7:0] ring_cnt;
    logic       match_done;
    logic       match, any_btn, set_mode, trigger;
    logic       ed_load, ed_next, ed_inc;

    assign match    = {now_hd, now_ho, now_md, now_mo} ==
                      {alarm_hd, alarm_ho, alarm_md, alarm_mo};
    assign any_btn  = btn_mode | btn_next | btn_inc;
    assign set_mode = (state == SET_TIME) || (state == SET_ALARM);
    assign trigger  = (state == RUN) && alarm_armed && match && !match_done;

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:       if (btn_mode) state_nx = SET_TIME;
                       else if (trigger) state_nx = RING;
            SET_TIME:  if (btn_mode) state_nx = SET_ALARM;
            SET_ALARM: if (btn_mode) state_nx = RUN;
            RING:      if (any_btn || (sec_tick && ring_cnt <= 8'd1)) state_nx = RUN;
        endcase
    end

    // Entering SET_TIME edits the live time; entering SET_ALARM edits the alarm.
    assign ed_load = btn_mode && ((state == RUN) || (state == SET_TIME));
    assign ed_next = set_mode && !btn_mode && btn_next;
    assign ed_inc  = set_mode && !btn_mode && !btn_next && btn_inc;
    assign src_hd  = (state == RUN) ? now_hd : alarm_hd;
    assign src_ho  = (state == RUN) ? now_ho : alarm_ho;
    assign src_md  = (state == RUN) ? now_md : alarm_md;
    assign src_mo  = (state == RUN) ? now_mo : alarm_mo;

    alarm_digit_edit u_edit (
        .clk        (clk),
        .rst        (rst),
        .load       (ed_load),
        .src_hd     (src_hd),
        .src_ho     (src_ho),
        .src_md     (src_md),
        .src_mo     (src_mo),
        .next       (ed_next),
        .inc        (ed_inc),
        .edit_hd    (edit_hd),
        .edit_ho    (edit_ho),
        .edit_md    (edit_md),
        .edit_mo    (edit_mo),
        .edit_digit (edit_digit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            alarm_hd    <= ALARM_RST_HD;
            alarm_ho    <= ALARM_RST_HO;
            alarm_md    <= ALARM_RST_MD;
            alarm_mo    <= ALARM_RST_MO;
            alarm_armed <= 1'b0;
            buzzer      <= 1'b0;
            load_en     <= 1'b0;
            set_hd      <= 4'd0;
            set_ho      <= 4'd0;
            set_md      <= 4'd0;
            set_mo      <= 4'd0;
            ring_cnt    <= 8'd0;
            match_done  <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state      <= state_nx;
            buzzer     <= (state_nx == RING);
            load_en    <= 1'b0;
            // Tracks equality every cycle so a match seen in any mode fires at most once.
            match_done <= match;

            if ((state_nx == RUN) || (state_nx == RING))
                blink <= 1'b0;
            else if (set_mode && sec_tick)
                blink <= ~blink;

            if ((state == RUN) && !btn_mode && btn_next)
                alarm_armed <= ~alarm_armed;

            if (trigger && !btn_mode)
                ring_cnt <= RING_LOAD;
            else if ((state == RING) && sec_tick && (ring_cnt != 8'd0))
                ring_cnt <= ring_cnt - 8'd1;

            if ((state == SET_TIME) && btn_mode) begin
                set_hd  <= edit_hd;
                set_ho  <= edit_ho;
                set_md  <= edit_md;
                set_mo  <= edit_mo;
                load_en <= 1'b1;
            end

            if ((state == SET_ALARM) && btn_mode) begin
                alarm_hd    <= edit_hd;
                alarm_ho    <= edit_ho;
                alarm_md    <= edit_md;
                alarm_mo    <= edit_mo;
                alarm_armed <= 1'b1;
            end
        end
    end

    assign mode    = state;
    assign disp_hd = set_mode ? edit_hd : now_hd;
    assign disp_ho = set_mode ? edit_ho : now_ho;
    assign disp_md = set_mode ? edit_md : now_md;
    assign disp_mo = set_mode ? edit_mo : now_mo;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed scenarios then random traffic,
// each cycle's expected outputs come from a behavioural watch model.
module tb_alarm_ctrl;

    localparam int RS = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, sec_tick = 1'b0;
    logic [3:0] now_hd = 4'd0, now_ho = 4'd0, now_md = 4'd0, now_mo = 4'd0;
    logic       load_en, blink, alarm_armed, buzzer;
    logic [3:0] set_hd, set_ho, set_md, set_mo;
    logic [3:0] disp_hd, disp_ho, disp_md, disp_mo;
    logic [1:0] edit_digit, mode;

    alarm_ctrl #(.RING_SECONDS(RS)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .sec_tick(sec_tick),
        .now_hd(now_hd), .now_ho(now_ho), .now_md(now_md), .now_mo(now_mo),
        .load_en(load_en),
        .set_hd(set_hd), .set_ho(set_ho), .set_md(set_md), .set_mo(set_mo),
        .disp_hd(disp_hd), .disp_ho(disp_ho), .disp_md(disp_md), .disp_mo(disp_mo),
        .edit_digit(edit_digit), .blink(blink), .mode(mode),
        .alarm_armed(alarm_armed), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        md;
        bit        buzz;
        bit        armed;
        bit        load;
        bit [15:0] set;
        bit [15:0] disp;
        int        ptr;
        bit        blk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    // Reference model: 0=RUN 1=SET_TIME 2=SET_ALARM 3=RING
    int m_mode, m_ptr, m_ring;
    int m_edit[4], m_alarm[4], m_set[4];
    bit m_armed, m_done, m_load, m_blink;

    function automatic int dig(bit [15:0] v, int i);
        return int'(v[15-4*i -: 4]);
    endfunction

    function automatic bit [15:0] pk(int d[4]);
        return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    endfunction

    task automatic m_inc();
        int lim[4];
        lim = '{2, (m_edit[0] == 2) ? 3 : 9, 5, 9};
        m_edit[m_ptr] = (m_edit[m_ptr] < lim[m_ptr]) ? m_edit[m_ptr] + 1 : 0;
        if (m_ptr == 0 && m_edit[0] == 2 && m_edit[1] > 3) m_edit[1] = 3;
    endtask

    task automatic m_step(bit r, bit bm, bit bn, bit bi, bit tk, bit [15:0] nw);
        bit match, was_set, old_armed;
        if (r) begin
            m_mode = 0; m_ptr = 0; m_ring = 0;
            m_edit = '{0, 0, 0, 0}; m_alarm = '{0, 7, 0, 0}; m_set = '{0, 0, 0, 0};
            m_armed = 0; m_done = 0; m_load = 0; m_blink = 0;
            return;
        end
        match = 1;
        for (int i = 0; i < 4; i++) if (dig(nw, i) != m_alarm[i]) match = 0;
        was_set = (m_mode == 1 || m_mode == 2);
        m_load = 0;
        case (m_mode)
            0: begin
                if (bm) begin
                    for (int i = 0; i < 4; i++) m_edit[i] = dig(nw, i);
                    m_ptr = 0; m_mode = 1;
                end else begin
                    old_armed = m_armed;
                    if (bn) m_armed = !m_armed;
                    if (old_armed && match && !m_done) begin m_mode = 3; m_ring = RS; end
                end
            end
            1, 2: begin
                if (bm) begin
                    if (m_mode == 1) begin
                        m_set = m_edit; m_load = 1; m_edit = m_alarm; m_ptr = 0; m_mode = 2;
                    end else begin
                        m_alarm = m_edit; m_armed = 1; m_mode = 0;
                    end
                end else if (bn) m_ptr = (m_ptr + 1) % 4;
                else if (bi) m_inc();
            end
            default: begin
                if (bm || bn || bi) m_mode = 0;
                else if (tk) begin
                    m_ring--;
                    if (m_ring == 0) m_mode = 0;
                end
            end
        endcase
        m_done = match;
        if (m_mode == 0 || m_mode == 3) m_blink = 0;
        else if (was_set && tk) m_blink = !m_blink;
    endtask

    task automatic cyc(bit r, bit bm, bit bn, bit bi, bit tk, bit [15:0] nw);
        exp_t e;
        @(negedge clk);
        rst = r; btn_mode = bm; btn_next = bn; btn_inc = bi; sec_tick = tk;
        {now_hd, now_ho, now_md, now_mo} = nw;
        m_step(r, bm, bn, bi, tk, nw);
        e.md = m_mode; e.buzz = (m_mode == 3); e.armed = m_armed; e.load = m_load;
        e.set = pk(m_set); e.ptr = m_ptr; e.blk = m_blink;
        e.disp = (m_mode == 1 || m_mode == 2) ? pk(m_edit) : nw;
        q.push_back(e);
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_no, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc_no++;
                chk("mode",        int'(mode),        e.md);
                chk("buzzer",      int'(buzzer),      int'(e.buzz));
                chk("alarm_armed", int'(alarm_armed), int'(e.armed));
                chk("load_en",     int'(load_en),     int'(e.load));
                chk("set",         int'({set_hd, set_ho, set_md, set_mo}), int'(e.set));
                chk("disp",        int'({disp_hd, disp_ho, disp_md, disp_mo}), int'(e.disp));
                chk("edit_digit",  int'(edit_digit),  e.ptr);
                chk("blink",       int'(blink),       int'(e.blk));
            end
        end
    end

    initial begin
        bit [15:0] nw, last;
        int sel;
        // Reset with buttons held, then idle at 12:34
        repeat (3) cyc(1, 1, 1, 1, 0, 16'h1234);
        repeat (3) cyc(0, 0, 0, 0, 0, 16'h1234);
        // Time set from 19:59 to 23:09
        cyc(0, 1, 0, 0, 0, 16'h1959);
        cyc(0, 0, 0, 1, 0, 16'h1959);
        cyc(0, 0, 1, 0, 0, 16'h1959);
        cyc(0, 0, 1, 0, 1, 16'h1959);
        cyc(0, 0, 0, 1, 0, 16'h1959);
        cyc(0, 0, 0, 0, 1, 16'h1959);
        cyc(0, 1, 0, 0, 0, 16'h1959);
        cyc(0, 0, 0, 0, 1, 16'h1959);
        // Alarm edit 07:00 -> 06:45
        cyc(0, 0, 1, 0, 0, 16'h1959);
        repeat (9) cyc(0, 0, 0, 1, 0, 16'h1959);
        cyc(0, 0, 1, 0, 0, 16'h1959);
        repeat (4) cyc(0, 0, 0, 1, 0, 16'h1959);
        cyc(0, 0, 1, 0, 0, 16'h1959);
        repeat (5) cyc(0, 0, 0, 1, 0, 16'h1959);
        cyc(0, 1, 0, 0, 0, 16'h1959);
        cyc(0, 0, 0, 0, 0, 16'h1959);
        // Full ring, then no retrigger while the time still matches
        cyc(0, 0, 0, 0, 0, 16'h0645);
        for (int i = 0; i < RS; i++) begin
            cyc(0, 0, 0, 0, 1, 16'h0645);
            cyc(0, 0, 0, 0, 0, 16'h0645);
        end
        repeat (4) cyc(0, 0, 0, 0, 1, 16'h0645);
        // Dismiss, disarm, no ring on next match
        cyc(0, 0, 0, 0, 0, 16'h1200);
        cyc(0, 0, 0, 0, 0, 16'h0645);
        cyc(0, 0, 0, 0, 1, 16'h0645);
        cyc(0, 0, 0, 1, 0, 16'h0645);
        cyc(0, 0, 1, 0, 0, 16'h0645);
        cyc(0, 0, 0, 0, 0, 16'h1200);
        repeat (3) cyc(0, 0, 0, 0, 0, 16'h0645);
        // Invalid BCD copied into the edit buffer increments to 0
        cyc(0, 1, 0, 0, 0, 16'h3A7C);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0, 16'h3A7C);
            cyc(0, 0, 1, 0, 0, 16'h3A7C);
        end
        cyc(0, 1, 0, 0, 0, 16'h3A7C);
        cyc(0, 1, 0, 0, 0, 16'h3A7C);
        // Simultaneous mode+inc in SET_TIME, then reset mid-ring
        cyc(0, 1, 0, 0, 0, 16'h1200);
        cyc(0, 0, 0, 1, 0, 16'h1200);
        cyc(0, 1, 0, 1, 0, 16'h1200);
        cyc(0, 1, 0, 0, 0, 16'h1200);
        cyc(0, 0, 0, 0, 0, 16'h1200);
        cyc(0, 0, 0, 0, 0, 16'h0645);
        cyc(0, 0, 0, 0, 1, 16'h0645);
        cyc(1, 0, 0, 0, 0, 16'h0645);
        repeat (2) cyc(0, 0, 0, 0, 0, 16'h0645);
        // Random traffic
        last = 16'h1234;
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) nw = pk(m_alarm);
            else if (sel < 5) nw = last;
            else if (sel < 9) nw = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                                    4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            else nw = 16'($urandom());
            last = nw;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) == 0), nw);
        end
        cyc(0, 0, 0, 0, 0, 16'h0000);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
